// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter.
// Imported by the interface, the picker and the top.
package mem_bus_pkg;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 64;

    localparam int REQ_FETCH = 0;
    localparam int REQ_LSU   = 1;
    localparam int REQ_WB    = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory-side signals of the arbiter.
// slave = arbiter view, master = requesters + memory view.
interface mem_bus_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = mem_bus_pkg::DEFAULT_ADDR_W,
    parameter int DATA_W  = mem_bus_pkg::DEFAULT_DATA_W
) ();

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_accept;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]         resp_data;
    logic                      resp_error;

    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic [ADDR_W-1:0]         mem_addr;
    logic                      mem_write;
    logic [DATA_W-1:0]         mem_wdata;
    logic                      mem_resp_valid;
    logic [DATA_W-1:0]         mem_resp_data;
    logic                      spurious_resp;

    modport slave (
        input  req_valid, req_addr, req_write, req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output req_accept, resp_valid, resp_data, resp_error,
        output mem_req_valid, mem_addr, mem_write, mem_wdata,
        output spurious_resp
    );

    modport master (
        output req_valid, req_addr, req_write, req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  req_accept, resp_valid, resp_data, resp_error,
        input  mem_req_valid, mem_addr, mem_write, mem_wdata,
        input  spurious_resp
    );

endinterface

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Combinational round-robin search: first set request
// after last_i, wrapping, as a one-hot grant.
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               found_o
);

    logic [IDX_W-1:0] idx;

    // Scan from last_i+1 upward; the first hit wins.
    always_comb begin
        grant_o = '0;
        found_o = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((int'(last_i) + k) % NUM_REQ);
            if (!found_o && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between
// requesters, one outstanding transaction at a time.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int ADDR_W         = DEFAULT_ADDR_W,
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic              clk,
    input logic              reset,
    mem_bus_arbiter_if.slave bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]   rr_last_q, rr_last_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               write_q, write_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]  resp_data_q, resp_data_d;
    logic               resp_error_q, resp_error_d;
    logic               spurious_q, spurious_d;

    logic [NUM_REQ-1:0] grant;
    logic               found;
    logic [IDX_W-1:0]   win_idx;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i   (bus.req_valid),
        .last_i  (rr_last_q),
        .grant_o (grant),
        .found_o (found)
    );

    // Encode the one-hot grant into an index for latching.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) win_idx = IDX_W'(i);
        end
    end

    // Next-state, latch and response generation.
    always_comb begin
        state_d      = state_q;
        grant_idx_d  = grant_idx_q;
        rr_last_d    = rr_last_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        resp_valid_d = '0;
        resp_data_d  = '0;
        resp_error_d = 1'b0;
        spurious_d   = spurious_q;
        unique case (state_q)
            IDLE: begin
                if (bus.mem_resp_valid) spurious_d = 1'b1;
                if (found) begin
                    addr_d      = bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
                    write_d     = bus.req_write[win_idx];
                    wdata_d     = bus.req_wdata[int'(win_idx)*DATA_W +: DATA_W];
                    grant_idx_d = win_idx;
                    rr_last_d   = win_idx;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_resp_valid) spurious_d = 1'b1;
                if (bus.mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                // A response on the limit cycle still wins.
                if (bus.mem_resp_valid) begin
                    resp_valid_d[grant_idx_q] = 1'b1;
                    resp_data_d = write_q ? '0 : bus.mem_resp_data;
                    state_d     = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    resp_valid_d[grant_idx_q] = 1'b1;
                    resp_error_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_idx_q  <= '0;
            rr_last_q    <= IDX_W'(NUM_REQ - 1);
            cnt_q        <= '0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_error_q <= 1'b0;
            spurious_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_idx_q  <= grant_idx_d;
            rr_last_q    <= rr_last_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_error_q <= resp_error_d;
            spurious_q   <= spurious_d;
        end
    end

    assign bus.req_accept    = (state_q == IDLE && !reset) ? grant : '0;
    assign bus.mem_req_valid = (state_q == ISSUE);
    assign bus.mem_addr      = addr_q;
    assign bus.mem_write     = write_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_data     = resp_data_q;
    assign bus.resp_error    = resp_error_q;
    assign bus.spurious_resp = spurious_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a response
// scoreboard popped by a negedge monitor.
module tb_mem_bus_arbiter;

    typedef struct packed {
        logic [2:0]  vld;
        logic [63:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;
    int exp_last;
    int w;

    exp_t sbq[$];
    exp_t e;

    mem_bus_arbiter_if #(.NUM_REQ(3), .ADDR_W(32), .DATA_W(64)) bus ();

    mem_bus_arbiter #(
        .NUM_REQ        (3),
        .ADDR_W         (32),
        .DATA_W         (64),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else begin
            fail_cnt = fail_cnt + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a,
                           input logic wr, input logic [63:0] d);
        bus.req_addr[i*32 +: 32]  = a;
        bus.req_write[i]          = wr;
        bus.req_wdata[i*64 +: 64] = d;
    endtask

    // Response monitor: every resp pulse must match the queue head.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.resp_valid !== 3'b000) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_resp", 64'(bus.resp_valid), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("resp_valid", 64'(bus.resp_valid), 64'(e.vld));
                    chk("resp_data", bus.resp_data, e.data);
                    chk("resp_error", 64'(bus.resp_error), 64'(e.err));
                end
            end else begin
                chk("quiet_resp_zero",
                    bus.resp_data | 64'(bus.resp_error), 64'd0);
            end
        end
    end

    initial begin
        bus.req_valid      = 3'b111;
        bus.req_addr       = '0;
        bus.req_write      = '0;
        bus.req_wdata      = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;

        // Reset state, accept gated while in reset
        @(negedge clk);
        chk("rst_accept", 64'(bus.req_accept), 64'd0);
        chk("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_spurious", 64'(bus.spurious_resp), 64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        cyc();
        reset = 1'b0;
        bus.req_valid = 3'b000;

        // Single load from fetch
        cyc();
        set_req(0, 32'h100, 1'b0, 64'd0);
        bus.req_valid = 3'b001;
        @(negedge clk);
        chk("t1_accept", 64'(bus.req_accept), 64'b001);
        sbq.push_back('{3'b001, 64'hDEADBEEF, 1'b0});
        cyc();
        bus.req_valid = 3'b000;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        chk("t1_mem_req_valid", 64'(bus.mem_req_valid), 64'd1);
        chk("t1_mem_addr", 64'(bus.mem_addr), 64'h100);
        chk("t1_mem_write", 64'(bus.mem_write), 64'd0);
        cyc();
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
        chk("t1_wait_no_req", 64'(bus.mem_req_valid), 64'd0);
        cyc();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 64'hDEADBEEF;
        cyc();
        bus.mem_resp_valid = 1'b0;
        exp_last = 0;

        // Fairness with all three requesting continuously
        for (int i = 0; i < 3; i++)
            set_req(i, 32'h1000 + 32'(i) * 32'h10, 1'b0, 64'd0);
        bus.req_valid = 3'b111;
        for (int n = 0; n < 6; n++) begin
            w = (exp_last + 1) % 3;
            @(negedge clk);
            chk("fair_accept", 64'(bus.req_accept), 64'd1 << w);
            sbq.push_back('{3'(1 << w), 64'hA000 + 64'(n), 1'b0});
            exp_last = w;
            cyc();
            bus.mem_req_ready = 1'b1;
            @(negedge clk);
            chk("fair_addr", 64'(bus.mem_addr),
                64'h1000 + 64'(w) * 64'h10);
            cyc();
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = 64'hA000 + 64'(n);
            cyc();
            bus.mem_resp_valid = 1'b0;
        end
        bus.req_valid = 3'b000;

        // Backpressure: store from LSU held in ISSUE for 5 cycles
        cyc();
        set_req(1, 32'h2222, 1'b1, 64'h55AA);
        bus.req_valid = 3'b010;
        @(negedge clk);
        chk("bp_accept", 64'(bus.req_accept), 64'b010);
        sbq.push_back('{3'b010, 64'd0, 1'b0});
        cyc();
        bus.req_valid = 3'b000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 64'(bus.mem_req_valid), 64'd1);
            chk("bp_addr", 64'(bus.mem_addr), 64'h2222);
            chk("bp_wdata", bus.mem_wdata, 64'h55AA);
            chk("bp_write", 64'(bus.mem_write), 64'd1);
            cyc();
        end
        bus.mem_req_ready = 1'b1;
        cyc();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 64'h1234;
        cyc();
        bus.mem_resp_valid = 1'b0;

        // Timeout: store from writeback, no response
        set_req(2, 32'h3330, 1'b1, 64'h77);
        bus.req_valid = 3'b100;
        @(negedge clk);
        chk("to_accept", 64'(bus.req_accept), 64'b100);
        sbq.push_back('{3'b100, 64'd0, 1'b1});
        cyc();
        bus.req_valid = 3'b000;
        bus.mem_req_ready = 1'b1;
        bus.mem_resp_data = 64'hBAD;
        cyc();
        bus.mem_req_ready = 1'b0;
        cyc();
        cyc();
        cyc();
        @(negedge clk);
        chk("to_no_early", 64'(bus.resp_valid), 64'd0);
        chk("to_wait_no_req", 64'(bus.mem_req_valid), 64'd0);
        cyc();
        set_req(0, 32'h4000, 1'b0, 64'd0);
        bus.req_valid = 3'b001;
        @(negedge clk);
        chk("to_resp_now", 64'(bus.resp_valid), 64'b100);
        chk("to_new_accept", 64'(bus.req_accept), 64'b001);
        sbq.push_back('{3'b001, 64'hCAFE, 1'b0});

        // Boundary: response on the limit cycle
        cyc();
        bus.req_valid = 3'b000;
        bus.mem_req_ready = 1'b1;
        cyc();
        bus.mem_req_ready = 1'b0;
        cyc();
        cyc();
        cyc();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 64'hCAFE;
        cyc();
        bus.mem_resp_valid = 1'b0;
        @(negedge clk);
        chk("bnd_resp_now", 64'(bus.resp_valid), 64'b001);

        // Spurious response in IDLE, sticky
        chk("sp_before", 64'(bus.spurious_resp), 64'd0);
        cyc();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 64'hEEEE;
        cyc();
        bus.mem_resp_valid = 1'b0;
        @(negedge clk);
        chk("sp_set", 64'(bus.spurious_resp), 64'd1);
        cyc();
        cyc();
        @(negedge clk);
        chk("sp_sticky", 64'(bus.spurious_resp), 64'd1);

        // Reset in WAIT_RESP aborts the transaction
        cyc();
        set_req(1, 32'h5550, 1'b0, 64'd0);
        bus.req_valid = 3'b010;
        @(negedge clk);
        chk("ra_accept", 64'(bus.req_accept), 64'b010);
        cyc();
        bus.req_valid = 3'b000;
        bus.mem_req_ready = 1'b1;
        cyc();
        bus.mem_req_ready  = 1'b0;
        reset              = 1'b1;
        bus.req_valid      = 3'b111;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 64'h9999;
        #1;
        chk("ra_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("ra_spurious", 64'(bus.spurious_resp), 64'd0);
        chk("ra_accept_gated", 64'(bus.req_accept), 64'd0);
        chk("ra_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("ra_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        cyc();
        bus.mem_resp_valid = 1'b0;
        cyc();
        set_req(0, 32'h6000, 1'b0, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ra_first_winner", 64'(bus.req_accept), 64'b001);
        chk("ra_spurious_after", 64'(bus.spurious_resp), 64'd0);
        sbq.push_back('{3'b001, 64'h6666, 1'b0});
        cyc();
        bus.req_valid = 3'b000;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        chk("ra_mem_addr2", 64'(bus.mem_addr), 64'h6000);
        cyc();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 64'h6666;
        cyc();
        bus.mem_resp_valid = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("sb_empty", 64'(sbq.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one memory port between NUM_REQ pipeline requesters: fetch, load/store and writeback.
- Allows one outstanding transaction at a time.
- Uses round-robin arbitration, forwards the request to memory, and routes the response back to the winner.
- Sits between the fetch/execute stages and the memory bus model, alongside the stage-to-stage buses.

Parameters:
NUM_REQ, 3, number of requesters; index 0=fetch, 1=load/store, 2=writeback
ADDR_W, 32, address width
DATA_W, 64, data width
TIMEOUT_CYCLES, 255, maximum wait for mem_resp_valid before an error response; must be 1..255

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request pending
req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
req_write  in  NUM_REQ  1=store, 0=load
req_wdata  in  NUM_REQ*DATA_W  packed store data
req_accept  out  NUM_REQ  one-hot; request taken this cycle
resp_valid  out  NUM_REQ  one-hot response pulse
resp_data  out  DATA_W  load data; 0 for stores and errors
resp_error  out  1  qualifies resp_valid; timeout occurred
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts the request
mem_addr  out  ADDR_W  latched address
mem_write  out  1  latched write flag
mem_wdata  out  DATA_W  latched store data
mem_resp_valid  in  1  memory response
mem_resp_data  in  DATA_W  memory load data
spurious_resp  out  1  sticky; set when mem_resp_valid arrives outside WAIT_RESP

Behaviour:
- Reset values: all outputs 0; state=IDLE; rr_last=NUM_REQ-1, so requester 0 has first priority; timeout counter 0.
- Reset asserted mid-transaction aborts it immediately. No response is delivered and the memory request drops.
- States and transitions:
  - IDLE: winner = first asserted req_valid searching from (rr_last+1) mod NUM_REQ upward with wrap.
    - req_accept[winner] is combinational, in the same cycle as the search.
    - At the edge, latch the winner's addr/write/wdata into mem_*, set grant_idx=winner and rr_last=winner, then go to ISSUE.
    - No req_valid: stay in IDLE, req_accept=0.
  - ISSUE: mem_req_valid=1 with the latched fields held stable.
    - mem_req_ready=1: go to WAIT_RESP and clear the counter.
    - Otherwise hold. ISSUE has no timeout.
  - WAIT_RESP: mem_req_valid=0; counter increments each cycle.
    - mem_resp_valid=1: at the next edge assert resp_valid[grant_idx]=1 for one cycle, resp_data=mem_resp_data (0 if write), resp_error=0, then go to IDLE.
    - Counter reaches TIMEOUT_CYCLES with no response: pulse resp_valid[grant_idx] with resp_error=1, resp_data=0, then go to IDLE.
    - A response in the same cycle the counter hits the limit counts as a response; no error is raised.
- Latency:
  - Accept at cycle T; mem_req_valid from T+1.
  - mem_req_ready at T+1 is the best case; then WAIT_RESP starts at T+2.
  - mem_resp_valid at cycle R gives resp_valid at R+1, and IDLE arbitrates again at R+1.
  - Back-to-back transactions are therefore spaced at least 3 cycles apart.
- Response outputs are registered and are 0 in every cycle without a response.
- spurious_resp sets on mem_resp_valid in IDLE or ISSUE. It clears only on reset. The spurious beat is otherwise ignored.
- Requesters must hold req_* until req_accept. Dropping req_valid before accept is legal and simply loses that arbitration.

Decomposition:
- Shared package mem_bus_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT_RESP);
  - requester index localparams REQ_FETCH=0, REQ_LSU=1, REQ_WB=2;
  - the default ADDR_W/DATA_W.
- One sub-module rr_picker: purely combinational round-robin search, taking req vector and last index, returning a one-hot grant plus a found flag.

Test Plan:
- Single load: req_valid=3'b001, addr 0x100; memory ready immediately and responds 2 cycles later with 0xDEADBEEF -> req_accept=001 at T, mem_addr=0x100 at T+1, resp_valid=001 with data 0xDEADBEEF.
- Fairness: all three requesting continuously, memory 1-cycle response -> grant order 0,1,2,0,1,2, with no requester granted twice before the others.
- Backpressure: mem_req_ready held low 5 cycles -> mem_req_valid and mem_addr stay stable 5 cycles, no timeout, a single transaction results.
- Timeout: TIMEOUT_CYCLES=4, store from requester 2, no response -> resp_valid=100, resp_error=1, resp_data=0 after 4 WAIT_RESP cycles, then IDLE accepts a new request.
- Spurious/reset: mem_resp_valid pulsed in IDLE -> spurious_resp=1 and sticky. Reset asserted in WAIT_RESP -> all outputs 0 asynchronously, no resp_valid, requester 0 wins first after reset.
- Boundary: response in the same cycle the counter hits the limit -> resp_error=0 with valid data.
